// File: rtl/playseq_sequenciador_n.sv
// PlaySeq engine: banked sequence RAM, LED preview, press checking,
// per-play timeout and record mode driven straight from the buttons.
module playseq_sequenciador_n #(
  parameter int W         = 4,
  parameter int ADDR      = 4,
  parameter int BANKS     = 4,
  parameter int T_JOGADA  = 5000,
  parameter int T_LED     = 500,
  parameter int T_APAGADO = 100,
  localparam int BW = (BANKS > 1) ? $clog2(BANKS) : 1
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            iniciar,
  input  logic            gravar,
  input  logic [BW-1:0]   banco,
  input  logic [ADDR-1:0] tam_inicial,
  input  logic [W-1:0]    botoes,
  output logic [W-1:0]    leds,
  output logic            pronto,
  output logic            acertou,
  output logic            errou,
  output logic            timeout,
  output logic [3:0]      db_estado,
  output logic [ADDR-1:0] db_endereco,
  output logic [ADDR-1:0] db_limite,
  output logic [W-1:0]    db_jogada
);

  localparam int DEPTH = 2 ** ADDR;
  localparam int AW    = BW + ADDR;
  localparam int TM1   = (T_LED > T_APAGADO) ? T_LED : T_APAGADO;
  localparam int TMAX  = (T_JOGADA > TM1) ? T_JOGADA : TM1;
  localparam int TW    = $clog2(TMAX + 1);

  localparam logic [BW:0]   BANKS_W  = (BW + 1)'(BANKS);
  localparam logic [BW-1:0] BANK_MAX = BW'(BANKS - 1);

  typedef enum logic [3:0] {
    S_INICIAL = 4'd0,
    S_PREPARA = 4'd1,
    S_MOSTRA  = 4'd2,
    S_APAGA   = 4'd3,
    S_ESPERA  = 4'd4,
    S_COMPARA = 4'd5,
    S_PROXIMA = 4'd6,
    S_GRAVA   = 4'd7,
    S_ACERTO  = 4'd8,
    S_ERRO    = 4'd9,
    S_TMO     = 4'd10
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [ADDR-1:0] r_end;
  logic [ADDR-1:0] r_lim;
  logic [BW-1:0]   r_bank;
  logic            r_rec;
  logic [TW-1:0]   r_tmr;
  logic            r_prev;
  logic [W-1:0]    r_jog;
  logic [W-1:0]    r_rdata;
  logic [W-1:0]    r_mem [BANKS*DEPTH];

  logic [ADDR-1:0] w_end_nxt;
  logic [ADDR-1:0] w_lim_nxt;
  logic [BW-1:0]   w_bank_nxt;
  logic [BW-1:0]   w_banco_cl;
  logic [AW-1:0]   w_rd_idx;
  logic [AW-1:0]   w_wr_idx;

  logic w_any;
  logic w_jogada;
  logic w_match;
  logic w_end_last;
  logic w_end_full;
  logic w_lim_full;
  logic w_led_done;
  logic w_dark_done;
  logic w_tmo_done;

  logic w_start;
  logic w_wr;
  logic w_show_adv;
  logic w_cmp_adv;
  logic w_rnd;
  logic w_cnt_en;
  logic w_cap;

  // rising edge of "any button" is one play
  assign w_any    = |botoes;
  assign w_jogada = w_any & ~r_prev;

  assign w_match    = (r_jog == r_rdata);
  assign w_end_last = (r_end == r_lim);
  assign w_end_full = (r_end == {ADDR{1'b1}});
  assign w_lim_full = (r_lim == {ADDR{1'b1}});

  assign w_led_done  = (r_tmr == TW'(T_LED - 1));
  assign w_dark_done = (r_tmr == TW'(T_APAGADO - 1));
  assign w_tmo_done  = (r_tmr == TW'(T_JOGADA - 1));

  assign w_banco_cl = ({1'b0, banco} >= BANKS_W)
                    ? BANK_MAX : banco;

  assign w_wr_idx = {r_bank, r_end};
  assign w_rd_idx = {w_bank_nxt, w_end_nxt};

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= S_INICIAL;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_INICIAL, S_ACERTO, S_ERRO, S_TMO:
        if (iniciar) w_state_nxt = S_PREPARA;
      S_PREPARA:
        w_state_nxt = r_rec ? S_GRAVA : S_MOSTRA;
      S_MOSTRA:
        if (w_led_done) w_state_nxt = S_APAGA;
      S_APAGA:
        if (w_dark_done)
          w_state_nxt = w_end_last ? S_ESPERA : S_MOSTRA;
      S_ESPERA:
        if (w_jogada)        w_state_nxt = S_COMPARA;
        else if (w_tmo_done) w_state_nxt = S_TMO;
      S_COMPARA:
        if (!w_match)        w_state_nxt = S_ERRO;
        else if (!w_end_last) w_state_nxt = S_ESPERA;
        else if (w_lim_full) w_state_nxt = S_ACERTO;
        else                 w_state_nxt = S_PROXIMA;
      S_PROXIMA:
        w_state_nxt = S_MOSTRA;
      S_GRAVA:
        if (w_jogada && w_end_full) w_state_nxt = S_ACERTO;
      default:
        w_state_nxt = S_INICIAL;
    endcase
  end

  always_comb begin
    leds       = '0;
    pronto     = 1'b0;
    acertou    = 1'b0;
    errou      = 1'b0;
    timeout    = 1'b0;
    w_start    = 1'b0;
    w_wr       = 1'b0;
    w_show_adv = 1'b0;
    w_cmp_adv  = 1'b0;
    w_rnd      = 1'b0;
    w_cnt_en   = 1'b0;
    w_cap      = 1'b0;
    unique case (r_state)
      S_INICIAL: begin
        pronto  = 1'b1;
        w_start = iniciar;
      end
      S_ACERTO: begin
        pronto  = 1'b1;
        acertou = 1'b1;
        w_start = iniciar;
      end
      S_ERRO: begin
        pronto  = 1'b1;
        errou   = 1'b1;
        w_start = iniciar;
      end
      S_TMO: begin
        pronto  = 1'b1;
        timeout = 1'b1;
        w_start = iniciar;
      end
      S_MOSTRA: begin
        leds     = r_rdata;
        w_cnt_en = 1'b1;
      end
      S_APAGA: begin
        w_cnt_en   = 1'b1;
        w_show_adv = w_dark_done;
      end
      S_ESPERA: begin
        leds     = botoes;
        w_cnt_en = 1'b1;
        w_cap    = 1'b1;
      end
      S_COMPARA:
        w_cmp_adv = w_match & ~w_end_last;
      S_PROXIMA:
        w_rnd = 1'b1;
      S_GRAVA: begin
        leds  = botoes;
        w_cap = 1'b1;
        w_wr  = w_jogada;
      end
      default: ;
    endcase
  end

  always_comb begin
    w_end_nxt  = r_end;
    w_lim_nxt  = r_lim;
    w_bank_nxt = r_bank;
    unique case (1'b1)
      w_start: begin
        w_bank_nxt = w_banco_cl;
        w_lim_nxt  = gravar ? {ADDR{1'b1}} : tam_inicial;
        w_end_nxt  = '0;
      end
      w_wr:
        if (!w_end_full) w_end_nxt = r_end + 1'b1;
      w_show_adv:
        w_end_nxt = w_end_last ? '0 : r_end + 1'b1;
      w_cmp_adv:
        w_end_nxt = r_end + 1'b1;
      w_rnd: begin
        w_lim_nxt = r_lim + 1'b1;
        w_end_nxt = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_end  <= '0;
      r_lim  <= '0;
      r_bank <= '0;
      r_rec  <= 1'b0;
      r_tmr  <= '0;
      r_prev <= 1'b0;
      r_jog  <= '0;
    end else begin
      r_end  <= w_end_nxt;
      r_lim  <= w_lim_nxt;
      r_bank <= w_bank_nxt;
      r_prev <= w_any;
      if (w_start)
        r_rec <= gravar;
      if (w_state_nxt != r_state)
        r_tmr <= '0;
      else if (w_cnt_en)
        r_tmr <= r_tmr + 1'b1;
      if (w_jogada && w_cap)
        r_jog <= botoes;
    end
  end

  // read address is the next-cycle address so data lines up with state
  always_ff @(posedge clock) begin
    if (w_wr)
      r_mem[w_wr_idx] <= botoes;
    r_rdata <= r_mem[w_rd_idx];
  end

  assign db_estado   = r_state;
  assign db_endereco = r_end;
  assign db_limite   = r_lim;
  assign db_jogada   = r_jog;

endmodule
